// File: rtl/forth_pkg.sv
// Shared definitions for the Forth core data path: cell width, stack error
// codes and the error-state enum used by the data stack.
package forth_pkg;

    localparam int WIDTH = 3;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;

    typedef enum logic [1:0] {
        ST_OK  = 2'd0,
        ST_OVF = 2'd1,
        ST_UNF = 2'd2
    } err_state_e;

    function automatic logic [1:0] state_to_code(input err_state_e s);
        case (s)
            ST_OVF:  return ERR_OVF;
            ST_UNF:  return ERR_UNF;
            default: return ERR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/data_stack_if.sv
// Control/status bundle between the Forth control unit (master) and the data
// stack (slave). DATA_STACK_PEEK_EN adds the peek_idx/peek_data debug port.
interface data_stack_if #(
    parameter int WIDTH = forth_pkg::WIDTH,
    parameter int DEPTH = 8
) ();
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic             err_clr;
    logic [WIDTH-1:0] top;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             err;
    logic [1:0]       err_code;
`ifdef DATA_STACK_PEEK_EN
    logic [AW-1:0]    peek_idx;
    logic [WIDTH-1:0] peek_data;

    modport master (
        output push, pop, push_data, err_clr, peek_idx,
        input  top, depth, empty, full, err, err_code, peek_data
    );
    modport slave (
        input  push, pop, push_data, err_clr, peek_idx,
        output top, depth, empty, full, err, err_code, peek_data
    );
`else
    modport master (
        output push, pop, push_data, err_clr,
        input  top, depth, empty, full, err, err_code
    );
    modport slave (
        input  push, pop, push_data, err_clr,
        output top, depth, empty, full, err, err_code
    );
`endif

endinterface

// File: rtl/dstack_mem.sv
// Register array for the data stack: one write port and combinational reads
// (a second read port exists when DATA_STACK_PEEK_EN is defined).
module dstack_mem #(
    parameter int WIDTH = forth_pkg::WIDTH,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
`ifdef DATA_STACK_PEEK_EN
    ,
    input  logic [AW-1:0]    i_praddr,
    output logic [WIDTH-1:0] o_prdata
`endif
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] w_row_we;

    // One-hot row enables; contents are never reset, sp alone defines validity.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row_we
            assign w_row_we[gi] = i_we && (i_waddr == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_row_we[i]) begin
                r_mem[i] <= i_wdata;
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

`ifdef DATA_STACK_PEEK_EN
    assign o_prdata = r_mem[i_praddr];
`endif

endmodule

// File: rtl/data_stack.sv
// LIFO holding every entry below T, with depth flags and a sticky
// overflow/underflow error FSM. DATA_STACK_PEEK_EN enables the peek port.
module data_stack #(
    parameter int WIDTH = forth_pkg::WIDTH,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    data_stack_if.slave  bus
);
    import forth_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [DW-1:0]    r_sp;
    logic [DW-1:0]    w_sp_next;
    err_state_e       r_state;
    err_state_e       w_state_next;

    logic             w_empty;
    logic             w_full;
    logic             w_ill_push;
    logic             w_ill_pop;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_top_addr;
    logic [WIDTH-1:0] w_rdata;

    assign w_empty    = (r_sp == '0);
    assign w_full     = (r_sp == DW'(DEPTH));
    // Modulo-DEPTH arithmetic also gives the right row when sp == DEPTH.
    assign w_top_addr = r_sp[AW-1:0] - AW'(1);

    assign w_ill_push = bus.push && !bus.pop && w_full;
    assign w_ill_pop  = bus.pop && !bus.push && w_empty;

    // Push+pop on a non-empty stack overwrites the top in place; on an empty
    // stack it falls through to the plain push path.
    always_comb begin
        w_sp_next = r_sp;
        w_we      = 1'b0;
        w_waddr   = r_sp[AW-1:0];
        if (bus.push && bus.pop && !w_empty) begin
            w_we    = 1'b1;
            w_waddr = w_top_addr;
        end else if (bus.push && !w_full) begin
            w_we      = 1'b1;
            w_waddr   = r_sp[AW-1:0];
            w_sp_next = r_sp + DW'(1);
        end else if (bus.pop && !bus.push && !w_empty) begin
            w_sp_next = r_sp - DW'(1);
        end
    end

    // First error wins while latched, but a fresh error beats a same-cycle clear.
    always_comb begin
        w_state_next = bus.err_clr ? ST_OK : r_state;
        if (w_ill_push && (r_state == ST_OK || bus.err_clr)) begin
            w_state_next = ST_OVF;
        end else if (w_ill_pop && (r_state == ST_OK || bus.err_clr)) begin
            w_state_next = ST_UNF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp    <= '0;
            r_state <= ST_OK;
        end else begin
            r_sp    <= w_sp_next;
            r_state <= w_state_next;
        end
    end

`ifdef DATA_STACK_PEEK_EN
    logic [AW-1:0]    w_peek_addr;
    logic [WIDTH-1:0] w_prdata;

    assign w_peek_addr = w_top_addr - bus.peek_idx;
`endif

    dstack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk      (clk),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (bus.push_data),
        .i_raddr  (w_top_addr),
        .o_rdata  (w_rdata)
`ifdef DATA_STACK_PEEK_EN
        ,
        .i_praddr (w_peek_addr),
        .o_prdata (w_prdata)
`endif
    );

    assign bus.top      = w_empty ? '0 : w_rdata;
    assign bus.depth    = r_sp;
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.err      = (r_state != ST_OK);
    assign bus.err_code = state_to_code(r_state);

`ifdef DATA_STACK_PEEK_EN
    assign bus.peek_data = (DW'(bus.peek_idx) < r_sp) ? w_prdata : '0;
`endif

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: table of one-cycle vectors with a
// scoreboard queue, plus hand sequences for error priority and peek.
module tb_data_stack;

    localparam int W = 3;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    data_stack_if #(.WIDTH(W), .DEPTH(D)) dsif ();

    data_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dsif.slave)
    );

    typedef struct {
        logic       r;
        logic       push;
        logic       pop;
        logic [2:0] data;
        logic       clr;
        logic [2:0] top;
        logic [3:0] depth;
        logic       empty;
        logic       full;
        logic       err;
        logic [1:0] code;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   txn          = 0;

    function automatic vec_t mk(input logic r, input logic p, input logic q,
                                input int d, input logic c, input int t,
                                input int dp, input logic e, input logic f,
                                input logic er, input int cd);
        vec_t v;
        v.r = r; v.push = p; v.pop = q; v.data = 3'(d); v.clr = c;
        v.top = 3'(t); v.depth = 4'(dp); v.empty = e; v.full = f;
        v.err = er; v.code = 2'(cd);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL txn %0d %s: got %0d expected %0d", txn, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        rst            = v.r;
        dsif.push      = v.push;
        dsif.pop       = v.pop;
        dsif.push_data = v.data;
        dsif.err_clr   = v.clr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("top",      int'(dsif.top),      int'(e.top));
        check("depth",    int'(dsif.depth),    int'(e.depth));
        check("empty",    int'(dsif.empty),    int'(e.empty));
        check("full",     int'(dsif.full),     int'(e.full));
        check("err",      int'(dsif.err),      int'(e.err));
        check("err_code", int'(dsif.err_code), int'(e.code));
        $display("[TB] txn %0d rst=%0b push=%0b pop=%0b data=%0d clr=%0b -> top=%0d depth=%0d err=%0b code=%0d",
                 txn, v.r, v.push, v.pop, v.data, v.clr,
                 dsif.top, dsif.depth, dsif.err, dsif.err_code);
        txn++;
    endtask

`ifdef DATA_STACK_PEEK_EN
    task automatic peek(input int idx, input int exp);
        dsif.peek_idx = 3'(idx);
        #1;
        check($sformatf("peek[%0d]", idx), int'(dsif.peek_data), exp);
        $display("[TB] peek idx=%0d -> %0d", idx, dsif.peek_data);
    endtask
`endif

    initial begin
        rst = 1'b1;
        dsif.push = 1'b0; dsif.pop = 1'b0; dsif.push_data = '0; dsif.err_clr = 1'b0;
`ifdef DATA_STACK_PEEK_EN
        dsif.peek_idx = '0;
`endif
        //          r p q d c  top dp e f er cd
        tbl.push_back(mk(1,0,0,0,0, 0,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,0,0));
        tbl.push_back(mk(0,1,0,3,0, 3,1,0,0,0,0));
        tbl.push_back(mk(0,1,0,5,0, 5,2,0,0,0,0));
        tbl.push_back(mk(0,1,0,7,0, 7,3,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 5,2,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 3,1,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 0,0,1,0,0,0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,1,0,i,0, i,i+1,0,(i == 7),0,0));
        tbl.push_back(mk(0,1,0,1,0, 7,8,0,1,1,1));   // overflow, ignored
        tbl.push_back(mk(0,0,0,0,1, 7,8,0,1,0,0));   // clear
        tbl.push_back(mk(0,1,1,5,0, 5,8,0,1,0,0));   // replace while full
        tbl.push_back(mk(0,0,1,0,0, 6,7,0,0,0,0));
        for (int k = 5; k >= 0; k--)
            tbl.push_back(mk(0,0,1,0,0, k,k+1,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 0,0,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 0,0,1,0,1,2));   // underflow
        tbl.push_back(mk(0,1,0,4,0, 4,1,0,0,1,2));
        tbl.push_back(mk(0,0,1,0,0, 0,0,1,0,1,2));
        tbl.push_back(mk(0,0,1,0,1, 0,0,1,0,1,2));   // clear loses to new error
        tbl.push_back(mk(0,0,0,0,1, 0,0,1,0,0,0));
        tbl.push_back(mk(0,1,0,1,0, 1,1,0,0,0,0));
        tbl.push_back(mk(0,1,0,6,0, 6,2,0,0,0,0));
        tbl.push_back(mk(0,1,1,2,0, 2,2,0,0,0,0));   // replace
        tbl.push_back(mk(0,0,1,0,0, 1,1,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 0,0,1,0,0,0));
        tbl.push_back(mk(0,1,1,5,0, 5,1,0,0,0,0));   // push+pop on empty = push
        tbl.push_back(mk(0,0,1,0,0, 0,0,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 0,0,1,0,1,2));
        tbl.push_back(mk(1,1,0,3,0, 0,0,1,0,0,0));   // reset beats push

        foreach (tbl[i]) apply(tbl[i]);

        // First error wins: overflow latched, later underflow leaves code 01.
        for (int i = 0; i < 8; i++)
            apply(mk(0,1,0,7-i,0, 7-i,i+1,0,(i == 7),0,0));
        apply(mk(0,1,0,0,0, 0,8,0,1,1,1));
        for (int i = 7; i >= 0; i--)
            apply(mk(0,0,1,0,0, (i == 0) ? 0 : 8-i,i,(i == 0),0,1,1));
        apply(mk(0,0,1,0,0, 0,0,1,0,1,1));
        apply(mk(0,1,0,2,0, 2,1,0,0,1,1));
        apply(mk(0,0,0,0,1, 2,1,0,0,0,0));

`ifdef DATA_STACK_PEEK_EN
        apply(mk(1,0,0,0,0, 0,0,1,0,0,0));
        apply(mk(0,1,0,1,0, 1,1,0,0,0,0));
        apply(mk(0,1,0,2,0, 2,2,0,0,0,0));
        apply(mk(0,1,0,3,0, 3,3,0,0,0,0));
        dsif.push = 1'b0;
        peek(0, 3);
        peek(1, 2);
        peek(2, 1);
        peek(3, 0);
        peek(7, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_stack.md
# data_stack

LIFO data stack behind the T (top-of-stack) register of the 3-bit Forth core. It holds every entry below T. It accepts T's outgoing value on a push, and on a pop it supplies the value that reloads T (it drives the T_In side). It also tracks depth and latches a sticky overflow/underflow error for the control unit.

## Interface
Parameters:
- WIDTH, 3, entry width in bits; matches T.
- DEPTH, 8, number of entries; power of two, minimum 2.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- push, input, 1, push push_data this cycle.
- pop, input, 1, remove the top entry this cycle.
- push_data, input, WIDTH, value spilled from T.
- err_clr, input, 1, clears the sticky error; returns the FSM to OK.
- top, output, WIDTH, current top entry (next-on-stack, N); 0 when empty.
- depth, output, clog2(DEPTH)+1, number of valid entries.
- empty, output, 1, depth == 0.
- full, output, 1, depth == DEPTH.
- err, output, 1, sticky error flag.
- err_code, output, 2, 00 none, 01 overflow, 10 underflow.

## Operation
- Storage: DEPTH x WIDTH register array plus stack pointer sp. sp equals depth; the top entry is at mem[sp-1].
- Push only, not full: mem[sp] <= push_data, sp increments.
- Pop only, not empty: sp decrements. The value needed to reload T is `top` as sampled in the same cycle pop is asserted.
- Push and pop together, not empty: replace. mem[sp-1] <= push_data, sp unchanged. This path is used by Forth SWAP/ALU ops and is legal when full.
- Push and pop together, empty: treated as a push only. No error.
- Push when full, without pop: ignored. Storage and sp are unchanged. FSM goes to OVF.
- Pop when empty, without push: ignored. FSM goes to UNF.
- Error FSM states: OK, OVF, UNF.
  - OK -> OVF on an illegal push.
  - OK -> UNF on an illegal pop.
  - OVF and UNF hold until err_clr is asserted, then go to OK.
  - While in OVF or UNF, a new illegal operation does not change the state; the first error wins.
  - Legal operations keep executing in every state.
- err_clr in the same cycle as an illegal operation: the new error wins and the FSM enters the corresponding error state.
- err = (state != OK). err_code is derived directly from the state.

## Timing
- Reset (rst high at a rising edge): sp = 0, depth = 0, empty = 1, full = 0, top = 0, err = 0, err_code = 00, FSM = OK. Array contents are not cleared and are don't-care.
- rst overrides push, pop and err_clr in the same cycle.
- An operation sampled at edge k is reflected on top/depth/full/empty/err after edge k, i.e. visible in cycle k+1 (one-cycle latency).
- top is combinational from registered state (mem and sp). It does not depend on same-cycle inputs.
- Back-to-back operations are supported every cycle with no stall.

## Configuration
- DATA_STACK_PEEK_EN defined: adds input peek_idx [clog2(DEPTH)-1:0] and output peek_data [WIDTH-1:0].
  - peek_data = mem[sp-1-peek_idx] when peek_idx < depth, else 0. Purely combinational, debug/OVER/PICK use.
- DATA_STACK_PEEK_EN undefined: these ports and the logic behind them do not exist.

## Structure
- Shared package forth_pkg: WIDTH constant (3), err_code encodings (ERR_NONE, ERR_OVF, ERR_UNF), FSM state enum.
- One sub-module, dstack_mem: register array with one write port and one (two with peek) combinational read ports.
- data_stack keeps sp, the FSM, and the flag logic.

## Test plan
- Reset, then idle: depth 0, empty 1, top 0, err 0.
- Push 3,5,7 on consecutive cycles: depth 3, top 7. Pop three times: top reads 7, 5, 3 before each pop. After the last pop, empty 1.
- Fill with DEPTH=8 pushes of values 0..7, then push 1 more: full 1, top 7, depth 8, err 1, err_code 01. Data is unchanged after err_clr.
- Pop on empty: err_code 10, depth stays 0. Then a push of 4 works: top 4, err still 1 until err_clr.
- With depth 2 and top 6, push+pop with push_data 2: depth 2, top 2. On a full stack, push+pop raises no error.
- Assert rst mid-sequence with push high: next cycle depth 0, err 0. With DATA_STACK_PEEK_EN, after pushes 1,2,3: peek_idx 2 gives peek_data 1, peek_idx 3 gives 0.
